// File: rtl/id_ex_pipe_if.sv
// Decode-to-execute pipeline register bundle: decode side inputs, EX-side registered copies.
// With ID_EX_PERF_EN defined the bundle also carries the stall/flush/bubble counters.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef MEM_ACCESS_TYPE_WIDTH
`define MEM_ACCESS_TYPE_WIDTH 3
`endif
`ifndef MEM_ACCESS_TYPE_NONE
`define MEM_ACCESS_TYPE_NONE 3'd0
`endif

interface id_ex_pipe_if #(
    parameter int unsigned ALU_OP_WIDTH = 5
);
    logic                              id_valid;
    logic [`CPU_WIDTH-1:0]             id_pc;
    logic [`CPU_WIDTH-1:0]             id_reg1_rdata;
    logic [`CPU_WIDTH-1:0]             id_reg2_rdata;
    logic [`CPU_WIDTH-1:0]             id_imm;
    logic [ALU_OP_WIDTH-1:0]           id_alu_op;
    logic [`REG_ADDR_WIDTH-1:0]        id_reg_waddr;
    logic                              id_reg_wen;
    logic [`MEM_ACCESS_TYPE_WIDTH-1:0] id_mem_access_type;
    logic                              id_mem_sign_ext;
    logic [1:0]                        id_forward_to_alu;
    logic                              ex_stall;
    logic                              flush;
    logic                              id_ready;

    logic                              ex_valid;
    logic [`CPU_WIDTH-1:0]             ex_pc;
    logic [`CPU_WIDTH-1:0]             ex_reg1;
    logic [`CPU_WIDTH-1:0]             ex_reg2;
    logic [`CPU_WIDTH-1:0]             ex_imm;
    logic [ALU_OP_WIDTH-1:0]           ex_alu_op;
    logic [`REG_ADDR_WIDTH-1:0]        ex_reg_waddr;
    logic                              ex_reg_wen;
    logic [`MEM_ACCESS_TYPE_WIDTH-1:0] ex_mem_access_type;
    logic                              ex_mem_sign_ext;
    logic [1:0]                        ex_forward_to_alu;
`ifdef ID_EX_PERF_EN
    logic [31:0]                       perf_stall_cnt;
    logic [31:0]                       perf_flush_cnt;
    logic [31:0]                       perf_bubble_cnt;
`endif

    modport master (
        output id_valid, id_pc, id_reg1_rdata, id_reg2_rdata, id_imm, id_alu_op,
               id_reg_waddr, id_reg_wen, id_mem_access_type, id_mem_sign_ext,
               id_forward_to_alu, ex_stall, flush,
        input  id_ready, ex_valid, ex_pc, ex_reg1, ex_reg2, ex_imm, ex_alu_op,
               ex_reg_waddr, ex_reg_wen, ex_mem_access_type, ex_mem_sign_ext,
               ex_forward_to_alu
`ifdef ID_EX_PERF_EN
        , input perf_stall_cnt, perf_flush_cnt, perf_bubble_cnt
`endif
    );

    modport slave (
        input  id_valid, id_pc, id_reg1_rdata, id_reg2_rdata, id_imm, id_alu_op,
               id_reg_waddr, id_reg_wen, id_mem_access_type, id_mem_sign_ext,
               id_forward_to_alu, ex_stall, flush,
        output id_ready, ex_valid, ex_pc, ex_reg1, ex_reg2, ex_imm, ex_alu_op,
               ex_reg_waddr, ex_reg_wen, ex_mem_access_type, ex_mem_sign_ext,
               ex_forward_to_alu
`ifdef ID_EX_PERF_EN
        , output perf_stall_cnt, perf_flush_cnt, perf_bubble_cnt
`endif
    );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: flush > stall > load priority, bubble insertion, x0-write suppression.
// Optional ID_EX_PERF_EN adds saturating stall/flush/bubble counters.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef MEM_ACCESS_TYPE_WIDTH
`define MEM_ACCESS_TYPE_WIDTH 3
`endif
`ifndef MEM_ACCESS_TYPE_NONE
`define MEM_ACCESS_TYPE_NONE 3'd0
`endif

module id_ex_pipe #(
    parameter int unsigned          ALU_OP_WIDTH = 5,
    parameter logic [`CPU_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    id_ex_pipe_if.slave bus
);
    localparam int unsigned XLEN = `CPU_WIDTH;
    localparam int unsigned RAW  = `REG_ADDR_WIDTH;
    localparam int unsigned MAW  = `MEM_ACCESS_TYPE_WIDTH;

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic [XLEN-1:0]         pc_q, pc_d, reg1_q, reg1_d, reg2_q, reg2_d, imm_q, imm_d;
    logic [ALU_OP_WIDTH-1:0] alu_op_q, alu_op_d;
    logic [RAW-1:0]          waddr_q, waddr_d;
    logic                    wen_q, wen_d;
    logic [MAW-1:0]          mat_q, mat_d;
    logic                    sext_q, sext_d;
    logic [1:0]              fwd_q, fwd_d;
    logic                    load_c, bubble_c;

    assign bus.id_ready = ~bus.ex_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_EMPTY;
            pc_q     <= RESET_PC;
            reg1_q   <= '0;
            reg2_q   <= '0;
            imm_q    <= '0;
            alu_op_q <= '0;
            waddr_q  <= '0;
            wen_q    <= 1'b0;
            mat_q    <= MAW'(`MEM_ACCESS_TYPE_NONE);
            sext_q   <= 1'b0;
            fwd_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            reg1_q   <= reg1_d;
            reg2_q   <= reg2_d;
            imm_q    <= imm_d;
            alu_op_q <= alu_op_d;
            waddr_q  <= waddr_d;
            wen_q    <= wen_d;
            mat_q    <= mat_d;
            sext_q   <= sext_d;
            fwd_q    <= fwd_d;
        end
    end

    // Flush beats stall; an idle, unstalled decode stage turns into a bubble.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        reg1_d   = reg1_q;
        reg2_d   = reg2_q;
        imm_d    = imm_q;
        alu_op_d = alu_op_q;
        waddr_d  = waddr_q;
        wen_d    = wen_q;
        mat_d    = mat_q;
        sext_d   = sext_q;
        fwd_d    = fwd_q;
        load_c   = 1'b0;
        bubble_c = 1'b0;

        if (bus.flush) begin
            bubble_c = 1'b1;
        end else if (!bus.ex_stall) begin
            load_c   = bus.id_valid;
            bubble_c = ~bus.id_valid;
        end

        case (state_q)
            S_EMPTY: if (load_c)   state_d = S_FULL;
            S_FULL:  if (bubble_c) state_d = S_EMPTY;
            default:               state_d = S_EMPTY;
        endcase

        if (bubble_c) begin
            pc_d     = RESET_PC;
            reg1_d   = '0;
            reg2_d   = '0;
            imm_d    = '0;
            alu_op_d = '0;
            waddr_d  = '0;
            wen_d    = 1'b0;
            mat_d    = MAW'(`MEM_ACCESS_TYPE_NONE);
            sext_d   = 1'b0;
            fwd_d    = 2'b00;
        end else if (load_c) begin
            pc_d     = bus.id_pc;
            reg1_d   = bus.id_reg1_rdata;
            reg2_d   = bus.id_reg2_rdata;
            imm_d    = bus.id_imm;
            alu_op_d = bus.id_alu_op;
            waddr_d  = bus.id_reg_waddr;
            // Writes to x0 are dropped here so later stages never see them.
            wen_d    = bus.id_reg_wen & (|bus.id_reg_waddr);
            mat_d    = bus.id_mem_access_type;
            sext_d   = bus.id_mem_sign_ext;
            fwd_d    = bus.id_forward_to_alu;
        end
    end

    assign bus.ex_valid           = (state_q == S_FULL);
    assign bus.ex_pc              = pc_q;
    assign bus.ex_reg1            = reg1_q;
    assign bus.ex_reg2            = reg2_q;
    assign bus.ex_imm             = imm_q;
    assign bus.ex_alu_op          = alu_op_q;
    assign bus.ex_reg_waddr       = waddr_q;
    assign bus.ex_reg_wen         = wen_q;
    assign bus.ex_mem_access_type = mat_q;
    assign bus.ex_mem_sign_ext    = sext_q;
    assign bus.ex_forward_to_alu  = fwd_q;

`ifdef ID_EX_PERF_EN
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] stall_cnt_q, flush_cnt_q, bubble_cnt_q;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (bus.ex_stall && !bus.flush && (stall_cnt_q != CNT_MAX))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (bus.flush && (flush_cnt_q != CNT_MAX))
                flush_cnt_q <= flush_cnt_q + 32'd1;
            if (bubble_c && (bubble_cnt_q != CNT_MAX))
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign bus.perf_stall_cnt  = stall_cnt_q;
    assign bus.perf_flush_cnt  = flush_cnt_q;
    assign bus.perf_bubble_cnt = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: directed vectors push expected EX contents, a monitor checks after each edge.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef MEM_ACCESS_TYPE_NONE
`define MEM_ACCESS_TYPE_NONE 3'd0
`endif

module tb_id_ex_pipe;
    localparam logic [31:0] RST_PC = 32'h0000_0080;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_pipe_if #(.ALU_OP_WIDTH(5)) bus();

    id_ex_pipe #(.ALU_OP_WIDTH(5), .RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, r1, r2, imm;
        logic [4:0]  op, wa;
        logic        wen;
        logic [2:0]  mat;
        logic        sx;
        logic [1:0]  fwd;
        logic        stall, flush;
    } vec_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, r1, r2, imm;
        logic [4:0]  op, wa;
        logic        wen;
        logic [2:0]  mat;
        logic        sx;
        logic [1:0]  fwd;
        logic        ready;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic valid, input logic [31:0] pc, input logic [31:0] r1,
                                input logic [31:0] r2, input logic [4:0] wa, input logic wen,
                                input logic [1:0] fwd, input logic stall, input logic flush);
        vec_t v;
        v.valid = valid; v.pc = pc; v.r1 = r1; v.r2 = r2;
        v.imm   = pc ^ 32'hFFFF_0000;
        v.op    = pc[6:2];
        v.wa    = wa; v.wen = wen;
        v.mat   = {1'b1, pc[3:2]};
        v.sx    = pc[2];
        v.fwd   = fwd; v.stall = stall; v.flush = flush;
        return v;
    endfunction

    function automatic exp_t exp_load(input vec_t v, input logic wen);
        exp_t e;
        e.valid = 1'b1; e.pc = v.pc; e.r1 = v.r1; e.r2 = v.r2; e.imm = v.imm;
        e.op = v.op; e.wa = v.wa; e.wen = wen; e.mat = v.mat; e.sx = v.sx;
        e.fwd = v.fwd; e.ready = 1'b1;
        return e;
    endfunction

    function automatic exp_t exp_bubble(input logic ready);
        exp_t e;
        e = '0;
        e.pc    = RST_PC;
        e.mat   = `MEM_ACCESS_TYPE_NONE;
        e.ready = ready;
        return e;
    endfunction

    function automatic exp_t exp_hold(input exp_t prev);
        exp_t e;
        e = prev;
        e.ready = 1'b0;
        return e;
    endfunction

    task automatic step(input vec_t v, input exp_t e);
        bus.id_valid           = v.valid;
        bus.id_pc              = v.pc;
        bus.id_reg1_rdata      = v.r1;
        bus.id_reg2_rdata      = v.r2;
        bus.id_imm             = v.imm;
        bus.id_alu_op          = v.op;
        bus.id_reg_waddr       = v.wa;
        bus.id_reg_wen         = v.wen;
        bus.id_mem_access_type = v.mat;
        bus.id_mem_sign_ext    = v.sx;
        bus.id_forward_to_alu  = v.fwd;
        bus.ex_stall           = v.stall;
        bus.flush              = v.flush;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " ex_valid"}, 32'(bus.ex_valid), 32'd0);
        chk({tag, " ex_pc"}, bus.ex_pc, RST_PC);
        chk({tag, " ex_reg_wen"}, 32'(bus.ex_reg_wen), 32'd0);
        chk({tag, " ex_mem_access_type"}, 32'(bus.ex_mem_access_type), 32'(`MEM_ACCESS_TYPE_NONE));
        chk({tag, " ex_forward_to_alu"}, 32'(bus.ex_forward_to_alu), 32'd0);
        chk({tag, " ex_reg1"}, bus.ex_reg1, 32'd0);
    endtask

    // Monitor: after every active edge out of reset, compare EX outputs with the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && (sb_q.size() > 0)) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("ex_valid", 32'(bus.ex_valid), 32'(e.valid));
                chk("ex_pc", bus.ex_pc, e.pc);
                chk("ex_reg1", bus.ex_reg1, e.r1);
                chk("ex_reg2", bus.ex_reg2, e.r2);
                chk("ex_imm", bus.ex_imm, e.imm);
                chk("ex_alu_op", 32'(bus.ex_alu_op), 32'(e.op));
                chk("ex_reg_waddr", 32'(bus.ex_reg_waddr), 32'(e.wa));
                chk("ex_reg_wen", 32'(bus.ex_reg_wen), 32'(e.wen));
                chk("ex_mem_access_type", 32'(bus.ex_mem_access_type), 32'(e.mat));
                chk("ex_mem_sign_ext", 32'(bus.ex_mem_sign_ext), 32'(e.sx));
                chk("ex_forward_to_alu", 32'(bus.ex_forward_to_alu), 32'(e.fwd));
                chk("id_ready", 32'(bus.id_ready), 32'(e.ready));
            end
        end
    end

    initial begin
        vec_t v;
        exp_t last;

        bus.id_valid = 1'b0; bus.id_pc = '0; bus.id_reg1_rdata = '0; bus.id_reg2_rdata = '0;
        bus.id_imm = '0; bus.id_alu_op = '0; bus.id_reg_waddr = '0; bus.id_reg_wen = 1'b0;
        bus.id_mem_access_type = '0; bus.id_mem_sign_ext = 1'b0; bus.id_forward_to_alu = 2'b00;
        bus.ex_stall = 1'b0; bus.flush = 1'b0;

        #12;
        chk_reset("por");
        chk("por id_ready", 32'(bus.id_ready), 32'd1);

        @(negedge clk);
        rst_n = 1'b1;

        // Normal flow
        v = mk(1, 32'h100, 32'h11, 32'h22, 5'd5, 1, 2'b00, 0, 0);  last = exp_load(v, 1'b1); step(v, last);
        // x0 destination: address copied, write enable dropped
        v = mk(1, 32'h200, 32'hAA, 32'hBB, 5'd0, 1, 2'b00, 0, 0);  last = exp_load(v, 1'b0); step(v, last);
        v = mk(1, 32'h104, 32'h33, 32'h44, 5'd7, 1, 2'b01, 0, 0);  last = exp_load(v, 1'b1); step(v, last);
        // Three stalled cycles with changing decode inputs
        v = mk(1, 32'h300, 32'h55, 32'h66, 5'd8, 1, 2'b11, 1, 0);  last = exp_hold(last); step(v, last);
        v = mk(0, 32'h304, 32'h57, 32'h67, 5'd9, 0, 2'b10, 1, 0);  last = exp_hold(last); step(v, last);
        v = mk(1, 32'h308, 32'h58, 32'h68, 5'd0, 1, 2'b00, 1, 0);  last = exp_hold(last); step(v, last);
        v = mk(1, 32'h108, 32'h77, 32'h88, 5'd10, 1, 2'b00, 0, 0); last = exp_load(v, 1'b1); step(v, last);
        // Flush wins over stall
        v = mk(1, 32'h400, 32'h99, 32'h9A, 5'd11, 1, 2'b11, 1, 1); last = exp_bubble(1'b0); step(v, last);
        // Load-use flag for operand 2, then cleared by a decode bubble
        v = mk(1, 32'h10C, 32'h12, 32'h34, 5'd9, 1, 2'b10, 0, 0); last = exp_load(v, 1'b1); step(v, last);
        v = mk(0, 32'h500, 32'hDE, 32'hAD, 5'd12, 1, 2'b11, 0, 0); last = exp_bubble(1'b1); step(v, last);
        // Stall while empty stays empty
        v = mk(1, 32'h600, 32'hBE, 32'hEF, 5'd13, 1, 2'b01, 1, 0); last = exp_hold(last); step(v, last);
        v = mk(1, 32'h604, 32'hC0, 32'hC1, 5'd14, 1, 2'b01, 0, 1); last = exp_bubble(1'b1); step(v, last);
        // Back-to-back loads
        v = mk(1, 32'h110, 32'hFFFF_FFFF, 32'h8000_0000, 5'd31, 1, 2'b11, 0, 0); last = exp_load(v, 1'b1); step(v, last);
        v = mk(1, 32'h114, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 5'd3, 1, 2'b01, 0, 0);  last = exp_load(v, 1'b1); step(v, last);

`ifdef ID_EX_PERF_EN
        chk("perf_stall_cnt", bus.perf_stall_cnt, 32'd4);
        chk("perf_flush_cnt", bus.perf_flush_cnt, 32'd2);
        chk("perf_bubble_cnt", bus.perf_bubble_cnt, 32'd3);
`endif

        // Asynchronous reset mid-cycle while a stalled instruction is held
        bus.ex_stall = 1'b1;
        chk("pre-reset ex_valid", 32'(bus.ex_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async");
`ifdef ID_EX_PERF_EN
        chk("reset perf_stall_cnt", bus.perf_stall_cnt, 32'd0);
        chk("reset perf_flush_cnt", bus.perf_flush_cnt, 32'd0);
        chk("reset perf_bubble_cnt", bus.perf_bubble_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        v = mk(1, 32'h120, 32'h1234_5678, 32'h9ABC_DEF0, 5'd20, 1, 2'b00, 0, 0); last = exp_load(v, 1'b1); step(v, last);
        v = mk(0, 32'h124, 32'h1, 32'h2, 5'd21, 1, 2'b00, 0, 0);               last = exp_bubble(1'b1); step(v, last);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        chk("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Pipeline register between decode/register-read and execute in the 5-stage RV32I core.
- Captures the operands the register file delivers, already forwarded, plus the decoded control and the per-operand forward_to_alu flags.
- Presents them to the ALU/EX stage.
- Handles downstream stall, branch/jump flush, bubble insertion and x0-write suppression.

Parameters:
- ALU_OP_WIDTH, 5, width of the decoded ALU operation code.
- RESET_PC, 32'h0000_0000, value of ex_pc after reset and in bubbles.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode stage holds a real instruction
- id_pc  in  `CPU_WIDTH  PC of decoded instruction
- id_reg1_rdata  in  `CPU_WIDTH  operand 1 from register file (post-forwarding)
- id_reg2_rdata  in  `CPU_WIDTH  operand 2 from register file (post-forwarding)
- id_imm  in  `CPU_WIDTH  sign-extended immediate
- id_alu_op  in  ALU_OP_WIDTH  ALU operation
- id_reg_waddr  in  `REG_ADDR_WIDTH  destination register
- id_reg_wen  in  1  destination write enable
- id_mem_access_type  in  `MEM_ACCESS_TYPE_WIDTH  load/store class
- id_mem_sign_ext  in  1  load sign extension
- id_forward_to_alu  in  2  bit0/bit1: operand 1/2 is taken from MEM-stage load data in EX
- ex_stall  in  1  EX or a later stage cannot accept a new instruction
- flush  in  1  branch/jump taken in EX; kill the instruction entering EX
- id_ready  out  1  decode may advance this cycle
- ex_valid, ex_pc, ex_reg1, ex_reg2, ex_imm, ex_alu_op, ex_reg_waddr, ex_reg_wen, ex_mem_access_type, ex_mem_sign_ext, ex_forward_to_alu  out  (same widths as id_*)  registered copies

Behaviour:
- Reset (async on rst_n low):
  - ex_valid=0, ex_reg_wen=0, ex_forward_to_alu=0, ex_pc=RESET_PC.
  - All data fields = 0.
  - ex_mem_access_type=`MEM_ACCESS_TYPE_NONE.
  - The register resumes on the first clk edge after rst_n rises. Reset mid-stall discards the held instruction.
- Latency: 1 cycle. id_* sampled on posedge clk appear on ex_* the same edge.
- id_ready = ~ex_stall. This path is combinational and does not depend on flush.
- Priority per edge: flush > ex_stall > load.
  - flush=1: insert bubble. ex_valid=0, ex_reg_wen=0, ex_mem_access_type=NONE, ex_forward_to_alu=0, ex_pc=RESET_PC, data fields 0. Applies even when ex_stall=1.
  - ex_stall=1, flush=0: all ex_* hold their value.
  - Otherwise, with id_valid=1: load all fields.
  - Otherwise, with id_valid=0: insert bubble, same as flush.
- x0 suppression: ex_reg_wen loads (id_reg_wen & id_reg_waddr!=0). ex_reg_waddr is still copied.
- Load-use: ex_forward_to_alu[i] loads id_forward_to_alu[i] only together with id_valid. EX selects MEM load data for operand i while the bit is set. The bit holds during a stall and clears on the bubble or the next load.
- FSM, 2 states:
  - EMPTY (ex_valid=0) to FULL on a load.
  - FULL to EMPTY on flush or a bubble.
  - FULL stays FULL on stall or load.
  - EMPTY stays EMPTY on stall.
- No arithmetic on data: fields pass through bit-exact, no width conversion.

Optional Feature:
- Macro ID_EX_PERF_EN.
- Defined: adds three 32-bit saturating counters reset to 0 and exposed as outputs perf_stall_cnt, perf_flush_cnt and perf_bubble_cnt.
  - perf_stall_cnt: +1 per cycle with ex_stall=1 and flush=0.
  - perf_flush_cnt: +1 per cycle with flush=1.
  - perf_bubble_cnt: +1 per edge that inserts a bubble for any reason.
  - Each counter holds at 32'hFFFF_FFFF.
- Not defined: the ports and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset: rst_n=0 mid-cycle with ex_valid=1 -> ex_valid=0, ex_reg_wen=0, ex_mem_access_type=NONE, ex_pc=RESET_PC immediately, without waiting for a clk edge.
- Normal flow: id_valid=1, id_pc=32'h100, reg1=32'h11, reg2=32'h22, waddr=5, wen=1 -> next edge ex_pc=32'h100, ex_reg1=32'h11, ex_reg2=32'h22, ex_reg_wen=1.
- x0 write: id_reg_waddr=0, id_reg_wen=1 -> ex_reg_wen=0, ex_valid=1.
- Stall: load pc 32'h104, then ex_stall=1 for 3 cycles while id_* change -> ex_pc stays 32'h104, id_ready=0 throughout. When released, the next id_* loads.
- Flush over stall: ex_stall=1 and flush=1 on the same edge -> ex_valid=0, ex_reg_wen=0, ex_forward_to_alu=0. With ID_EX_PERF_EN defined: perf_flush_cnt=1, perf_stall_cnt=0.
- Load-use: id_forward_to_alu=2'b10, id_valid=1 -> ex_forward_to_alu=2'b10 for one cycle. With id_valid=0 on the following edge -> ex_forward_to_alu=2'b00.
